pipe_hold_ctrl: RTL and testbench
=================================

Name: pipe_hold_ctrl

Overview:
Central pipeline hold/flush controller. It arbitrates jump and stall requests from EX, the bus arbiter and CLINT, and drives the registered hold level and jump redirect. The hold level feeds the hold_en inputs of the pipe DFFs in the if_id and id_ex stages, and the jump outputs feed the PC register. All outputs are registered, so downstream stages see glitch-free, single-source hold control.

Parameters:
FLUSH_CYC, 2, cycles hold_flag_o stays at HOLD_ID after an accepted jump (1..15)
BUS_TMO, 64, consecutive hold_bus_i cycles before bus_tmo_o is raised (2..1023)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
jump_req_i  input  1  EX requests a redirect (branch/jal/jalr/trap return)
jump_addr_i  input  32  redirect target, valid with jump_req_i
hold_ex_i  input  1  EX multi-cycle op (mul/div) busy
hold_bus_i  input  1  bus arbiter has taken the bus from the core
hold_clint_i  input  1  CLINT is processing an interrupt entry/exit
hold_flag_o  output  3  hold level: 0 none, 1 PC, 2 PC+IF, 3 PC+IF+ID
jump_flag_o  output  1  one-cycle redirect pulse to PC register
jump_addr_o  output  32  redirect target, valid while jump_flag_o=1
bus_tmo_o  output  1  sticky bus starvation flag

Behaviour:
- Reset (async, any time, including mid-flush or mid-stall): state=RUN, hold_flag_o=0, jump_flag_o=0, jump_addr_o=0, bus_tmo_o=0, all counters 0.
- States: RUN, FLUSH, STALL. Every output is registered; requests sampled in cycle N take effect in cycle N+1.
- Request level per cycle: jump_req_i→3; hold_clint_i→3; hold_ex_i→3; hold_bus_i→1. The effective level is the maximum of the active requests.
- Priority: jump_req_i > hold_clint_i > hold_ex_i > hold_bus_i.
- RUN:
  - jump_req_i → FLUSH; next cycle jump_flag_o=1, jump_addr_o=jump_addr_i, hold_flag_o=3, flush counter loaded with FLUSH_CYC-1.
  - Otherwise, any hold request → STALL with hold_flag_o=effective level.
  - Otherwise stay in RUN with hold_flag_o=0.
- FLUSH:
  - jump_flag_o is high for exactly the first FLUSH cycle, then 0. jump_addr_o holds its value until the next jump.
  - hold_flag_o=3 while the counter is nonzero; the counter decrements each cycle.
  - At counter=0: go to STALL if any hold request is active, else RUN.
  - A new jump_req_i in FLUSH restarts the flush: new pulse, new address, counter reloaded.
- STALL:
  - hold_flag_o tracks the effective level each cycle, with 1-cycle latency.
  - jump_req_i → FLUSH, as in RUN; a jump overrides a stall.
  - No requests → RUN with hold_flag_o=0 on the next cycle.
- Bus watchdog:
  - A 10-bit counter increments while hold_bus_i=1 and clears when it is 0.
  - When the count reaches BUS_TMO-1 with hold_bus_i still 1, bus_tmo_o is set on the next edge.
  - bus_tmo_o stays high until reset; it has no effect on hold_flag_o. The counter saturates and does not wrap.
- Simultaneous requests: jump plus any hold → FLUSH wins. Holds still asserted after the flush are honoured via STALL, never dropped.
- FLUSH_CYC=1: hold_flag_o=3 for one cycle only, the same cycle as jump_flag_o.

Optional Feature:
PIPE_HOLD_CTRL_PERF_EN:
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0.
  - stall_cnt_o increments on every cycle with hold_flag_o!=0.
  - flush_cnt_o increments on every accepted jump.
  - Both counters wrap modulo 2^32.
- Undefined: neither the ports nor the counters exist, and all other behaviour is identical.

Test Plan:
- Reset release, all requests 0 for 10 cycles → hold_flag_o=0, jump_flag_o=0, jump_addr_o=0, bus_tmo_o=0 throughout.
- jump_req_i=1 for one cycle with jump_addr_i=0x0000_0100, FLUSH_CYC=2 → next cycle jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3; the following cycle hold_flag_o=3, jump_flag_o=0; then hold_flag_o=0.
- hold_bus_i=1 for 3 cycles, overlapping hold_ex_i=1 on the 2nd cycle only → hold_flag_o sequence 1,3,1, then 0 one cycle after the requests drop.
- hold_ex_i=1 held while jump_req_i pulses (addr 0x8000_0000) → jump_flag_o pulse with addr 0x8000_0000; hold_flag_o stays 3 through FLUSH and STALL; it returns to 0 one cycle after hold_ex_i falls.
- hold_bus_i=1 for BUS_TMO=64 cycles → bus_tmo_o rises after the 64th cycle and stays 1 after hold_bus_i drops. A run of only 63 cycles leaves bus_tmo_o=0.
- rst_n asserted mid-FLUSH (counter=1) → all outputs go to 0 immediately, asynchronously. After release the block is in RUN with no residual jump pulse.

Source files
------------

// File: rtl/pipe_hold_ctrl_if.sv
// pipe_hold_ctrl_if
//   Groups the hold/flush controller handshake into one bundle.
//   Requests (into the controller):
//     jump_req_i, jump_addr_i[31:0]     EX redirect request and target
//     hold_ex_i, hold_bus_i, hold_clint_i  stall sources
//   Controls (out of the controller):
//     hold_flag_o[2:0]                  hold level to pipe DFFs
//     jump_flag_o, jump_addr_o[31:0]    redirect pulse/target to PC
//     bus_tmo_o                         sticky bus starvation flag
//   master: the request side (core/testbench); slave: the controller.
interface pipe_hold_ctrl_if;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        hold_clint_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        bus_tmo_o;

  modport master (
    output jump_req_i, jump_addr_i, hold_ex_i, hold_bus_i, hold_clint_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, bus_tmo_o
  );

  modport slave (
    input  jump_req_i, jump_addr_i, hold_ex_i, hold_bus_i, hold_clint_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, bus_tmo_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl
//   Central pipeline hold/flush controller. Arbitrates jump and stall
//   requests and drives a registered hold level plus a one-cycle jump
//   redirect. All outputs are registered (1-cycle request latency).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ctrl (slave)       request/control bundle, see pipe_hold_ctrl_if
//   stall_cnt_o[31:0]  cycles with nonzero hold level  (PIPE_HOLD_CTRL_PERF_EN)
//   flush_cnt_o[31:0]  accepted jumps                  (PIPE_HOLD_CTRL_PERF_EN)
// Parameters:
//   FLUSH_CYC  cycles hold level stays 3 after an accepted jump (1..15)
//   BUS_TMO    consecutive bus-hold cycles before bus_tmo_o rises (2..1023)
// Optional build macro: PIPE_HOLD_CTRL_PERF_EN adds the performance counters.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned BUS_TMO   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PIPE_HOLD_CTRL_PERF_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  pipe_hold_ctrl_if.slave   ctrl
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_STALL = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);
  localparam logic [9:0] BUS_LAST   = 10'(BUS_TMO - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  hold_flag_q, hold_flag_d;
  logic        jump_flag_q, jump_flag_d;
  logic [31:0] jump_addr_q, jump_addr_d;
  logic [9:0]  bus_cnt_q, bus_cnt_d;
  logic        bus_tmo_q, bus_tmo_d;

  logic        hold_req;
  logic [2:0]  req_lvl;

  // Effective level is the maximum of the active requests.
  always_comb begin
    hold_req = ctrl.hold_clint_i | ctrl.hold_ex_i | ctrl.hold_bus_i;
    if (ctrl.jump_req_i | ctrl.hold_clint_i | ctrl.hold_ex_i)
      req_lvl = 3'd3;
    else if (ctrl.hold_bus_i)
      req_lvl = 3'd1;
    else
      req_lvl = 3'd0;
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      hold_flag_q <= '0;
      jump_flag_q <= 1'b0;
      jump_addr_q <= '0;
      bus_cnt_q   <= '0;
      bus_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_flag_q <= hold_flag_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      bus_cnt_q   <= bus_cnt_d;
      bus_tmo_q   <= bus_tmo_d;
    end
  end

  // Next-state logic; a jump overrides everything in every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ctrl.jump_req_i) begin
      state_d = S_FLUSH;
      cnt_d   = FLUSH_LOAD;
    end else begin
      case (state_q)
        S_RUN:   state_d = hold_req ? S_STALL : S_RUN;
        S_FLUSH: begin
          if (cnt_q != '0)
            cnt_d = cnt_q - 4'd1;
          else
            state_d = hold_req ? S_STALL : S_RUN;
        end
        S_STALL: state_d = hold_req ? S_STALL : S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    hold_flag_d = '0;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    if (ctrl.jump_req_i) begin
      hold_flag_d = 3'd3;
      jump_flag_d = 1'b1;
      jump_addr_d = ctrl.jump_addr_i;
    end else begin
      case (state_q)
        S_RUN:   hold_flag_d = req_lvl;
        S_FLUSH: hold_flag_d = (cnt_q != '0) ? 3'd3 : req_lvl;
        S_STALL: hold_flag_d = req_lvl;
        default: hold_flag_d = '0;
      endcase
    end
  end

  // Bus watchdog: counter saturates at BUS_TMO-1 so it never wraps.
  always_comb begin
    bus_cnt_d = '0;
    bus_tmo_d = bus_tmo_q;
    if (ctrl.hold_bus_i) begin
      if (bus_cnt_q == BUS_LAST)
        bus_tmo_d = 1'b1;
      else
        bus_cnt_d = bus_cnt_q + 10'd1;
      if (bus_cnt_q == BUS_LAST)
        bus_cnt_d = bus_cnt_q;
    end
  end

  assign ctrl.hold_flag_o = hold_flag_q;
  assign ctrl.jump_flag_o = jump_flag_q;
  assign ctrl.jump_addr_o = jump_addr_q;
  assign ctrl.bus_tmo_o   = bus_tmo_q;

`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_flag_q != '0)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ctrl.jump_req_i)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
module tb_pipe_hold_ctrl;
  logic clk;
  logic rst_n;
  int unsigned errors;
  int unsigned checks;

  pipe_hold_ctrl_if bus ();

`ifdef PIPE_HOLD_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_hold_ctrl #(.FLUSH_CYC(2), .BUS_TMO(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef PIPE_HOLD_CTRL_PERF_EN
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt),
`endif
    .ctrl        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at this edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] hf, input logic jf,
                         input logic [31:0] ja, input logic tmo);
    chk({tag, ".hold"}, {29'd0, bus.hold_flag_o}, {29'd0, hf});
    chk({tag, ".jflag"}, {31'd0, bus.jump_flag_o}, {31'd0, jf});
    chk({tag, ".jaddr"}, bus.jump_addr_o, ja);
    chk({tag, ".tmo"}, {31'd0, bus.bus_tmo_o}, {31'd0, tmo});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.jump_req_i   = 1'b0;
    bus.jump_addr_i  = '0;
    bus.hold_ex_i    = 1'b0;
    bus.hold_bus_i   = 1'b0;
    bus.hold_clint_i = 1'b0;
    #3;
    chk_out("reset", 3'd0, 1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("idle", 3'd0, 1'b0, 32'h0, 1'b0);
    end

    // Single jump, FLUSH_CYC=2
    bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h0000_0100;
    tick();
    bus.jump_req_i = 1'b0; bus.jump_addr_i = 32'hDEAD_BEEF;
    chk_out("jmp1", 3'd3, 1'b1, 32'h100, 1'b0);
    tick();
    chk_out("jmp2", 3'd3, 1'b0, 32'h100, 1'b0);
    tick();
    chk_out("jmp3", 3'd0, 1'b0, 32'h100, 1'b0);

    // Bus hold 3 cycles, EX overlapping on 2nd
    bus.hold_bus_i = 1'b1;
    tick();
    chk("bus_ex1", {29'd0, bus.hold_flag_o}, 32'd1);
    bus.hold_ex_i = 1'b1;
    tick();
    chk("bus_ex2", {29'd0, bus.hold_flag_o}, 32'd3);
    bus.hold_ex_i = 1'b0;
    tick();
    chk("bus_ex3", {29'd0, bus.hold_flag_o}, 32'd1);
    bus.hold_bus_i = 1'b0;
    tick();
    chk("bus_ex4", {29'd0, bus.hold_flag_o}, 32'd0);

    // EX stall held across a jump
    bus.hold_ex_i = 1'b1;
    tick();
    chk("exj0", {29'd0, bus.hold_flag_o}, 32'd3);
    bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h8000_0000;
    tick();
    bus.jump_req_i = 1'b0;
    chk_out("exj1", 3'd3, 1'b1, 32'h8000_0000, 1'b0);
    tick();
    chk_out("exj2", 3'd3, 1'b0, 32'h8000_0000, 1'b0);
    tick();
    chk_out("exj3", 3'd3, 1'b0, 32'h8000_0000, 1'b0);
    tick();
    chk_out("exj4", 3'd3, 1'b0, 32'h8000_0000, 1'b0);
    bus.hold_ex_i = 1'b0;
    tick();
    chk_out("exj5", 3'd0, 1'b0, 32'h8000_0000, 1'b0);

    // Jump + CLINT together: flush wins, CLINT honoured afterwards
    bus.jump_req_i = 1'b1; bus.hold_clint_i = 1'b1; bus.jump_addr_i = 32'h0000_0044;
    tick();
    bus.jump_req_i = 1'b0;
    chk_out("jcl1", 3'd3, 1'b1, 32'h44, 1'b0);
    tick();
    chk_out("jcl2", 3'd3, 1'b0, 32'h44, 1'b0);
    tick();
    chk_out("jcl3", 3'd3, 1'b0, 32'h44, 1'b0);
    bus.hold_clint_i = 1'b0;
    tick();
    chk_out("jcl4", 3'd0, 1'b0, 32'h44, 1'b0);

    // Jump + bus hold: after flush, level drops to 1
    bus.jump_req_i = 1'b1; bus.hold_bus_i = 1'b1; bus.jump_addr_i = 32'h0000_0088;
    tick();
    bus.jump_req_i = 1'b0;
    chk_out("jbu1", 3'd3, 1'b1, 32'h88, 1'b0);
    tick();
    chk_out("jbu2", 3'd3, 1'b0, 32'h88, 1'b0);
    tick();
    chk_out("jbu3", 3'd1, 1'b0, 32'h88, 1'b0);
    bus.hold_bus_i = 1'b0;
    tick();
    chk_out("jbu4", 3'd0, 1'b0, 32'h88, 1'b0);

    // Back-to-back jumps restart the flush
    bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h0000_0200;
    tick();
    chk_out("bb1", 3'd3, 1'b1, 32'h200, 1'b0);
    bus.jump_addr_i = 32'h0000_0300;
    tick();
    bus.jump_req_i = 1'b0;
    chk_out("bb2", 3'd3, 1'b1, 32'h300, 1'b0);
    tick();
    chk_out("bb3", 3'd3, 1'b0, 32'h300, 1'b0);
    tick();
    chk_out("bb4", 3'd0, 1'b0, 32'h300, 1'b0);

    // Bus run of 63 cycles: no timeout
    bus.hold_bus_i = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    chk_out("tmo63", 3'd1, 1'b0, 32'h300, 1'b0);
    bus.hold_bus_i = 1'b0;
    tick();
    chk_out("tmo63b", 3'd0, 1'b0, 32'h300, 1'b0);

    // Bus run of 64 cycles: timeout after the 64th, sticky
    bus.hold_bus_i = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    chk("tmo64a", {31'd0, bus.bus_tmo_o}, 32'd0);
    tick();
    chk_out("tmo64b", 3'd1, 1'b0, 32'h300, 1'b1);
    bus.hold_bus_i = 1'b0;
    tick();
    chk_out("tmo64c", 3'd0, 1'b0, 32'h300, 1'b1);
    tick();
    chk("tmo64d", {31'd0, bus.bus_tmo_o}, 32'd1);

    // Async reset mid-flush (counter=1)
    bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h0000_0500;
    tick();
    bus.jump_req_i = 1'b0;
    chk_out("rstf0", 3'd3, 1'b1, 32'h500, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rstf1", 3'd0, 1'b0, 32'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("rstf2", 3'd0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_out("rstf3", 3'd0, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
